edge_trigger_array: RTL

//  N-channel parametrised edge-trigger unit, successor to the single-channel rising-edge trigger.
//  Per channel: input synchroniser, debounce filter, and rise/fall/both/off edge select.

---
 rtl/edge_trig_pkg.sv | 12 +
 rtl/edge_trig_chan.sv | 60 ++++++
 rtl/edge_trigger_array.sv | 38 +++
 3 files changed

// File: rtl/edge_trig_pkg.sv
// edge_trig_pkg: mode encodings and edge-enable helper shared by the edge trigger array
package edge_trig_pkg;
   localparam int MODE_W = 2;
   localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
   localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
   localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
   localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

   function automatic logic mode_hit(input logic [MODE_W-1:0] m, input logic rise);
      return rise ? (m == MODE_RISE || m == MODE_BOTH) : (m == MODE_FALL || m == MODE_BOTH);
   endfunction
endpackage

// File: rtl/edge_trig_chan.sv
// edge_trig_chan: one channel of synchroniser, debounce, edge select and sticky flags
module edge_trig_chan
   import edge_trig_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sig_i,
   input  logic [MODE_W-1:0] mode_i,
   input  logic              clr_i,
   output logic              level_o,
   output logic              trigger_o,
   output logic              pending_o,
   output logic              overrun_o
);
   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d, ev_q, ev_d, trig_q, pend_q, pend_d, ovr_q, ovr_d;
   logic                   s, accept;

   // ev_q carries the mode-qualified edge from the level-update edge to the trigger edge
   always_comb begin
      s       = sync_q[SYNC_STAGES-1];
      sync_d  = SYNC_STAGES'({sync_q, sig_i});
      accept  = (s != level_q) && (cnt_q == CW'(DEBOUNCE - 1));
      cnt_d   = (s == level_q || accept) ? '0 : cnt_q + CW'(1);
      level_d = accept ? s : level_q;
      ev_d    = accept && mode_hit(mode_i, s);
      pend_d  = ev_q ? 1'b1 : (clr_i ? 1'b0 : pend_q);
      ovr_d   = clr_i ? 1'b0 : ((ev_q && pend_q) ? 1'b1 : ovr_q);
   end

   always_ff @(posedge clk)
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         ev_q    <= 1'b0;
         trig_q  <= 1'b0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         ev_q    <= ev_d;
         trig_q  <= ev_q;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end

   assign level_o   = level_q;
   assign trigger_o = trig_q;
   assign pending_o = pend_q;
   assign overrun_o = ovr_q;
endmodule

// File: rtl/edge_trigger_array.sv
// edge_trigger_array: N independent debounced edge-trigger channels plus an any-pending flag
module edge_trigger_array
   import edge_trig_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH-1:0]        sig_in,
   input  logic [MODE_W*N_CH-1:0] mode,
   input  logic [N_CH-1:0]        clr,
   output logic [N_CH-1:0]        level,
   output logic [N_CH-1:0]        trigger,
   output logic [N_CH-1:0]        pending,
   output logic [N_CH-1:0]        overrun,
   output logic                   any_pending
);
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_trig_chan #(
         .SYNC_STAGES(SYNC_STAGES),
         .DEBOUNCE   (DEBOUNCE)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .sig_i    (sig_in[i]),
         .mode_i   (mode[MODE_W*i +: MODE_W]),
         .clr_i    (clr[i]),
         .level_o  (level[i]),
         .trigger_o(trigger[i]),
         .pending_o(pending[i]),
         .overrun_o(overrun[i])
      );
   end

   assign any_pending = |pending;
endmodule
